dm_ctrl: RTL and testbench

Parametrised data memory for the multi-cycle MIPS datapath. It replaces the fixed 1K-word, always-ready memory with a request/response handshake, configurable wait states, true byte-lane writes, and sub-word loads with sign or zero extension (LB/LBU/LH/LHU/LW, SB/SH/SW). It sits between the datapath's memory-stage control and the storage array, and asserts busy to stall the control FSM.

---
 rtl/dm_ctrl.sv | 156 +++++++++++++++
 tb/tb_dm_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dm_ctrl.sv
// Data memory for the multi-cycle MIPS datapath: request/response handshake, wait states,
// byte-lane stores and sign/zero-extended sub-word loads. Optional macro DM_MISALIGN_TRAP_EN.
module dm_ctrl #(
    parameter int    ADDR_W      = 12,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int DEPTH = 1 << (ADDR_W - 2);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t              state_q;
    logic [3:0]          wcnt_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          size_q;
    logic                uns_q;
    logic [31:0]         wdata_q;
    logic                resp_valid_q;
    logic [31:0]         resp_rdata_q;
    logic                resp_err_q;

    logic [31:0]         mem [DEPTH];

    logic [ADDR_W-3:0]   idx;
    logic [1:0]          lane;
    logic                misal;
    logic [3:0]          be;
    logic [31:0]         wdata_rep;
    logic [31:0]         rd_word;
    logic [31:0]         rd_shift;
    logic [31:0]         rdata_d;
    logic                commit;

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    // Access decode works only from the captured request, never from live inputs.
    always_comb begin
        idx   = addr_q[ADDR_W-1:2];
        lane  = addr_q[1:0];
        misal = 1'b0;
`ifdef DM_MISALIGN_TRAP_EN
        misal = (size_q == 2'b11) ||
                (size_q == 2'b01 && addr_q[0]) ||
                (size_q == 2'b10 && addr_q[1:0] != 2'b00);
`else
        if (size_q[1]) begin
            lane = 2'b00;
        end else if (size_q == 2'b01) begin
            lane[0] = 1'b0;
        end
`endif
        case (size_q)
            2'b00: begin
                be        = 4'b0001 << lane;
                wdata_rep = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << lane;
                wdata_rep = {2{wdata_q[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata_q;
            end
        endcase
        rd_word  = mem[idx];
        rd_shift = rd_word >> {lane, 3'b000};
        case (size_q)
            2'b00:   rdata_d = uns_q ? {24'd0, rd_shift[7:0]}
                                     : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   rdata_d = uns_q ? {16'd0, rd_shift[15:0]}
                                     : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: rdata_d = rd_word;
        endcase
        commit = rst_n && (state_q == S_ACCESS) && we_q && !misal;
    end

    // Array has no reset; a reset edge in ACCESS blocks the commit via rst_n in commit.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wcnt_q       <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        wdata_q <= req_wdata;
                        if (WAIT_STATES > 0) begin
                            wcnt_q  <= 4'(WAIT_STATES - 1);
                            state_q <= S_WAIT;
                        end else begin
                            state_q <= S_ACCESS;
                        end
                    end
                end
                S_WAIT: begin
                    if (wcnt_q == 4'd0) begin
                        state_q <= S_ACCESS;
                    end else begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end
                end
                S_ACCESS: begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= misal;
                    resp_rdata_q <= (we_q || misal) ? 32'd0 : rdata_d;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed bench for dm_ctrl: one instance with no wait states, one with three.
// Expectations follow DM_MISALIGN_TRAP_EN when the bench is built with it.
module tb_dm_ctrl;

    localparam int ADDR_W = 12;

    logic              clk;
    logic              rst_n      [2];
    logic              req_valid  [2];
    logic              req_ready  [2];
    logic              req_we     [2];
    logic [ADDR_W-1:0] req_addr   [2];
    logic [1:0]        req_size   [2];
    logic              req_unsigned [2];
    logic [31:0]       req_wdata  [2];
    logic              resp_valid [2];
    logic [31:0]       resp_rdata [2];
    logic              resp_err   [2];
    logic              busy       [2];

    int checks = 0;
    int errors = 0;

    dm_ctrl #(.ADDR_W(ADDR_W), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
        .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
        .resp_err(resp_err[0]), .busy(busy[0])
    );

    dm_ctrl #(.ADDR_W(ADDR_W), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst_n(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
        .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
        .resp_err(resp_err[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction; checks acceptance and latency, returns response fields.
    task automatic do_req(input int k, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                          input int exp_lat, input string tag,
                          output logic [31:0] rdata, output logic err);
        int lat;
        @(negedge clk);
        req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = addr;
        req_size[k] = size; req_unsigned[k] = uns; req_wdata[k] = wdata;
        check({tag, "_ready"}, 32'(req_ready[k]), 32'd1);
        @(posedge clk);
        #1 req_valid[k] = 1'b0;
        lat = 0;
        rdata = 32'hx; err = 1'bx;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (resp_valid[k]) begin
                rdata = resp_rdata[k];
                err = resp_err[k];
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    logic [31:0] rd;
    logic        er;
    logic        seen;

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
            req_size[k] = 2'b10; req_unsigned[k] = 1'b0; req_wdata[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        check("rst_ready", 32'(req_ready[0]), 32'd1);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_rvalid", 32'(resp_valid[0]), 32'd0);
        check("rst_rdata", resp_rdata[0], 32'd0);
        check("rst_err", 32'(resp_err[0]), 32'd0);
        check("rst_ready3", 32'(req_ready[1]), 32'd1);

        // Word store/load with no wait states
        do_req(0, 1'b1, 12'h010, 2'b10, 1'b0, 32'h12345678, 1, "sw0", rd, er);
        check("sw0_rdata", rd, 32'd0);
        check("sw0_err", 32'(er), 32'd0);
        do_req(0, 1'b0, 12'h010, 2'b10, 1'b0, 32'h0, 1, "lw0", rd, er);
        check("lw0_rdata", rd, 32'h12345678);

        // Byte lane store and sub-word loads
        do_req(0, 1'b1, 12'h011, 2'b00, 1'b0, 32'h000000AB, 1, "sb", rd, er);
        do_req(0, 1'b0, 12'h010, 2'b10, 1'b0, 32'h0, 1, "lw_sb", rd, er);
        check("lw_sb_rdata", rd, 32'h1234AB78);
        do_req(0, 1'b0, 12'h011, 2'b00, 1'b0, 32'h0, 1, "lb", rd, er);
        check("lb_rdata", rd, 32'hFFFFFFAB);
        do_req(0, 1'b0, 12'h011, 2'b00, 1'b1, 32'h0, 1, "lbu", rd, er);
        check("lbu_rdata", rd, 32'h000000AB);

        // Half store and loads
        do_req(0, 1'b1, 12'h012, 2'b01, 1'b0, 32'h00008001, 1, "sh", rd, er);
        do_req(0, 1'b0, 12'h012, 2'b01, 1'b0, 32'h0, 1, "lh", rd, er);
        check("lh_rdata", rd, 32'hFFFF8001);
        do_req(0, 1'b0, 12'h012, 2'b01, 1'b1, 32'h0, 1, "lhu", rd, er);
        check("lhu_rdata", rd, 32'h00008001);
        do_req(0, 1'b0, 12'h010, 2'b10, 1'b0, 32'h0, 1, "lw_sh", rd, er);
        check("lw_sh_rdata", rd, 32'h8001AB78);
        do_req(0, 1'b0, 12'h010, 2'b00, 1'b0, 32'h0, 1, "lb0", rd, er);
        check("lb0_rdata", rd, 32'h00000078);

        // Misaligned accesses
        do_req(0, 1'b0, 12'h013, 2'b10, 1'b0, 32'h0, 1, "lw_mis", rd, er);
`ifdef DM_MISALIGN_TRAP_EN
        check("lw_mis_rdata", rd, 32'd0);
        check("lw_mis_err", 32'(er), 32'd1);
`else
        check("lw_mis_rdata", rd, 32'h8001AB78);
        check("lw_mis_err", 32'(er), 32'd0);
`endif
        do_req(0, 1'b0, 12'h013, 2'b01, 1'b0, 32'h0, 1, "lh_mis", rd, er);
`ifdef DM_MISALIGN_TRAP_EN
        check("lh_mis_err", 32'(er), 32'd1);
`else
        check("lh_mis_rdata", rd, 32'h00008001 | 32'hFFFF0000);
        check("lh_mis_err", 32'(er), 32'd0);
`endif
        do_req(0, 1'b1, 12'h013, 2'b10, 1'b0, 32'hDEADBEEF, 1, "sw_mis", rd, er);
        do_req(0, 1'b0, 12'h010, 2'b10, 1'b0, 32'h0, 1, "lw_aft", rd, er);
`ifdef DM_MISALIGN_TRAP_EN
        check("lw_aft_rdata", rd, 32'h8001AB78);
`else
        check("lw_aft_rdata", rd, 32'hDEADBEEF);
`endif

        // Three wait states: busy/ready profile and ignored mid-wait request
        do_req(1, 1'b1, 12'h010, 2'b10, 1'b0, 32'h0BADF00D, 4, "sw3", rd, er);
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 12'h010;
        req_size[1] = 2'b10; req_unsigned[1] = 1'b0;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            check($sformatf("w3_busy%0d", i), 32'(busy[1]), 32'd1);
            check($sformatf("w3_ready%0d", i), 32'(req_ready[1]), 32'd0);
            check($sformatf("w3_rv%0d", i), 32'(resp_valid[1]), 32'd0);
            if (i == 1) begin
                req_valid[1] = 1'b1; req_we[1] = 1'b1; req_wdata[1] = 32'hFFFFFFFF;
            end
            if (i == 2) begin
                req_valid[1] = 1'b0; req_we[1] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("w3_rv", 32'(resp_valid[1]), 32'd1);
        check("w3_rdata", resp_rdata[1], 32'h0BADF00D);
        check("w3_busy_done", 32'(busy[1]), 32'd0);
        @(posedge clk);
        #1;
        check("w3_rv_pulse", 32'(resp_valid[1]), 32'd0);
        check("w3_rdata_hold", resp_rdata[1], 32'h0BADF00D);
        do_req(1, 1'b0, 12'h010, 2'b10, 1'b0, 32'h0, 4, "lw3b", rd, er);
        check("lw3b_rdata", rd, 32'h0BADF00D);

        // Reset during WAIT aborts a store
        do_req(1, 1'b1, 12'h020, 2'b10, 1'b0, 32'h11112222, 4, "sw_pre", rd, er);
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 12'h020;
        req_size[1] = 2'b10; req_wdata[1] = 32'h33334444;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        check("abort_busy", 32'(busy[1]), 32'd1);
        @(negedge clk);
        rst_n[1] = 1'b0;
        @(negedge clk);
        rst_n[1] = 1'b1;
        check("abort_ready", 32'(req_ready[1]), 32'd1);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (resp_valid[1]) seen = 1'b1;
        end
        check("abort_no_rv", 32'(seen), 32'd0);
        do_req(1, 1'b0, 12'h020, 2'b10, 1'b0, 32'h0, 4, "lw_abort", rd, er);
        check("lw_abort_rdata", rd, 32'h11112222);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
